// File: rtl/uart_pkg.sv
// Shared UART definitions: serialiser FSM state encoding and byte width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with first-word-fall-through head byte and occupancy count.
// Latency: a push is visible on o_rdata after the clock edge that accepts it.
// Backpressure: push is dropped when full unless a pop frees the slot in the same cycle.
//
// Ports: i_clk, i_rst (sync, active-high), i_push/i_wdata, i_pop,
//        o_rdata (head byte, 0 while empty), o_level (0..DEPTH), o_full, o_empty.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [UART_BYTE_W-1:0] i_wdata,
  input  logic                   i_pop,
  output logic [UART_BYTE_W-1:0] o_rdata,
  output logic [AW:0]            o_level,
  output logic                   o_full,
  output logic                   o_empty
);

  logic [UART_BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]          wptr;
  logic [AW-1:0]          rptr;
  logic                   pop_ok;
  logic                   push_ok;

  assign o_full  = (o_level == (AW+1)'(DEPTH));
  assign o_empty = (o_level == '0);

  // When full, the concurrent pop vacates the slot the push lands in
  // (wptr == rptr), so the head byte is read before it is overwritten.
  assign pop_ok  = i_pop && !o_empty;
  assign push_ok = i_push && (!o_full || pop_ok);

  // Pointers are AW bits wide so they wrap DEPTH-1 -> 0 on their own.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr    <= '0;
      rptr    <= '0;
      o_level <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   o_level <= o_level + (AW+1)'(1);
        2'b01:   o_level <= o_level - (AW+1)'(1);
        default: o_level <= o_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok && !i_rst) mem[wptr] <= i_wdata;
  end

  // Storage is not reset; masking keeps the head at 0 while empty.
  assign o_rdata = o_empty ? '0 : mem[rptr];

endmodule

// File: rtl/uart_txd_ser_fifo.sv
// Word-to-byte serialiser feeding a byte FIFO read by the UART transmitter.
// Latency: word written at edge E -> first byte on o_txd_fifo_rdata after edge E+1.
// Backpressure: serialiser holds while FIFO full (unless popped same cycle); writes while busy are dropped.
//
// Ports: i_clk, i_rst (sync, active-high); write side i_wr/i_wdata/i_wlen, o_busy, o_wr_err;
//        read side i_txd_fifo_rd, o_txd_fifo_rdata, o_txd_fifo_rempty, o_txd_fifo_full, o_level, o_rd_err;
//        i_clr_err clears both sticky error flags.
module uart_txd_ser_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int DEPTH     = 16,
  parameter  int MSB_FIRST = 1,
  localparam int NB        = DATA_W / 8,
  localparam int LW        = $clog2(NB) + 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr,
  input  logic [DATA_W-1:0]      i_wdata,
  input  logic [LW-1:0]          i_wlen,
  output logic                   o_busy,
  output logic                   o_wr_err,
  input  logic                   i_clr_err,
  input  logic                   i_txd_fifo_rd,
  output logic [UART_BYTE_W-1:0] o_txd_fifo_rdata,
  output logic                   o_txd_fifo_rempty,
  output logic                   o_txd_fifo_full,
  output logic [AW:0]            o_level,
  output logic                   o_rd_err
);

  ser_state_t        state_q;
  ser_state_t        state_d;
  logic [DATA_W-1:0] word_q;
  logic [LW-1:0]     idx_q;     // byte index of the next byte to push
  logic [LW-1:0]     cnt_q;     // bytes of the held word still to push
  logic [LW-1:0]     eff_len;
  logic              load;
  logic              push;
  logic              wr_drop;
  logic [DATA_W-1:0] word_sh;
  logic [UART_BYTE_W-1:0] push_byte;

  // A length of 0 or anything above NB means the whole word.
  assign eff_len = ((i_wlen == '0) || (i_wlen > LW'(NB))) ? LW'(NB) : i_wlen;

  assign word_sh   = word_q >> {idx_q, 3'b000};
  assign push_byte = word_sh[UART_BYTE_W-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    push    = 1'b0;
    wr_drop = 1'b0;
    o_busy  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_wr) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        o_busy  = 1'b1;
        wr_drop = i_wr;
        // A pop in the same cycle frees a slot even when full.
        if (!o_txd_fifo_full || i_txd_fifo_rd) begin
          push = 1'b1;
          if (cnt_q == LW'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      word_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      word_q <= i_wdata;
      cnt_q  <= eff_len;
      idx_q  <= (MSB_FIRST != 0) ? eff_len - LW'(1) : '0;
    end else if (push) begin
      cnt_q  <= cnt_q - LW'(1);
      idx_q  <= (MSB_FIRST != 0) ? idx_q - LW'(1) : idx_q + LW'(1);
    end
  end

  // Sticky errors: a new event in the same cycle as a clear wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wr_err <= 1'b0;
      o_rd_err <= 1'b0;
    end else begin
      if (wr_drop)        o_wr_err <= 1'b1;
      else if (i_clr_err) o_wr_err <= 1'b0;
      if (i_txd_fifo_rd && o_txd_fifo_rempty) o_rd_err <= 1'b1;
      else if (i_clr_err)                     o_rd_err <= 1'b0;
    end
  end

  uart_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_wdata (push_byte),
    .i_pop   (i_txd_fifo_rd),
    .o_rdata (o_txd_fifo_rdata),
    .o_level (o_level),
    .o_full  (o_txd_fifo_full),
    .o_empty (o_txd_fifo_rempty)
  );

endmodule

// File: doc/uart_txd_ser_fifo.md
UART_TXD_SER_FIFO -- requirements
Module: uart_txd_ser_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32; write-word width, a multiple of 8 in the range 8..64; NB = DATA_W/8.
REQ-002 SHALL have parameter DEPTH, default 16; byte-FIFO depth, a power of 2 in the range 4..256; AW = clog2(DEPTH).
REQ-003 SHALL have parameter MSB_FIRST, default 1; 1 = most significant valid byte is queued first, 0 = byte 0 is queued first.
REQ-004 i_clk  in  1  single clock; one clock; all logic rises on i_clk.
REQ-005 i_rst  in  1  reset; synchronous, active-high.
REQ-006 i_wr  in  1  write strobe, one cycle per word.
REQ-007 i_wdata  in  DATA_W  word to serialise.
REQ-008 i_wlen  in  clog2(NB)+1  valid byte count; 0 or any value >NB means NB.
REQ-009 o_busy  out  1  serialiser holds a word.
REQ-010 o_wr_err  out  1  sticky: a write was dropped.
REQ-011 i_clr_err  in  1  clears both sticky error flags.
REQ-012 i_txd_fifo_rd  in  1  pop request from the transmitter.
REQ-013 o_txd_fifo_rdata  out  8  head byte, first-word-fall-through.
REQ-014 o_txd_fifo_rempty  out  1  FIFO empty.
REQ-015 o_txd_fifo_full  out  1  FIFO full.
REQ-016 o_level  out  AW+1  FIFO occupancy, 0..DEPTH.
REQ-017 o_rd_err  out  1  sticky: a pop was attempted while empty.

Function
REQ-018 FSM SHALL have states IDLE and SHIFT; o_busy = 1 exactly in SHIFT.
REQ-019 In IDLE, i_wr=1 SHALL capture i_wdata and the effective length into internal registers and enter SHIFT on the next edge.
REQ-020 i_wr while in SHIFT SHALL be dropped without changing any state and SHALL set o_wr_err.
REQ-021 In SHIFT, one byte SHALL be pushed per cycle whenever the FIFO is not full, or is full with i_txd_fifo_rd=1 in the same cycle; otherwise the FSM SHALL hold.
REQ-022 Byte order SHALL be: MSB_FIRST=1 -> byte index len-1 down to 0; MSB_FIRST=0 -> index 0 up to len-1; bytes at index >= len SHALL never be pushed.
REQ-023 The cycle that pushes the last byte SHALL return the FSM to IDLE; an i_wr in the following cycle SHALL be accepted.
REQ-024 Latency: for an i_wr sampled at edge E into an empty FIFO, the first byte SHALL appear on o_txd_fifo_rdata and o_txd_fifo_rempty SHALL fall after edge E+1.
REQ-025 o_txd_fifo_rdata SHALL always show the oldest byte while not empty; it is don't-care while empty.
REQ-026 i_txd_fifo_rd while empty SHALL be ignored and SHALL set o_rd_err.
REQ-027 A simultaneous push and pop SHALL leave o_level unchanged; if full, the pop frees the slot and the push is accepted.
REQ-028 Read and write pointers SHALL be AW bits and wrap from DEPTH-1 to 0; full and empty SHALL be derived from o_level.
REQ-029 i_clr_err SHALL clear the sticky flags, and a new error event in the same cycle SHALL win.

Reset
REQ-030 i_rst SHALL force IDLE, pointers 0, o_level 0, o_txd_fifo_rempty 1, o_txd_fifo_full 0, o_busy 0, o_wr_err 0, o_rd_err 0, and o_txd_fifo_rdata 8'h00.
REQ-031 Reset mid-SHIFT SHALL discard the held word and all queued bytes; no byte from before reset SHALL be popped afterwards.
REQ-032 i_wr and i_txd_fifo_rd asserted together with i_rst SHALL be ignored.

Structure
REQ-033 A shared package uart_pkg SHALL hold the FSM state enum (ST_IDLE, ST_SHIFT) and the byte-width constant UART_BYTE_W = 8.
REQ-034 The byte FIFO SHALL be a sub-module uart_byte_fifo (parameter DEPTH; push/pop/level/full/empty); the serialiser FSM stays in the top module.

Verification
REQ-035 MSB_FIRST=1, 32'h12345678, len 4, rd held 1 -> pops 12,34,56,78; o_busy high for exactly 4 cycles.
REQ-036 MSB_FIRST=0, same word, len 3 -> pops 78,56,34 only; o_level peaks at 1 with rd=1, and reaches 3 with rd=0.
REQ-037 DEPTH=16, rd=0, write 5 words of len 4 back-to-back-when-idle -> o_level=16, full=1, o_busy stuck at 1; one pop -> one push in the same cycle, level stays 16.
REQ-038 i_wr during SHIFT -> word dropped, o_wr_err=1 until i_clr_err; pop on empty -> o_rd_err=1, o_level stays 0.
REQ-039 i_rst mid-SHIFT with 3 bytes queued -> next cycle rempty=1, level 0, busy 0; the next write 32'hA1B2C3D4 pops A1 first.
REQ-040 DATA_W=64, DEPTH=4, len 0 -> 8 bytes emitted in order under continuous rd, with pointer wrap exercised twice.
